mac_nibble_serial: RTL and testbench

MAC_NIBBLE_SERIAL -- requirements
Module: mac_nibble_serial

---
 rtl/mac_nibble_serial.sv | 146 ++++++++++++++
 tb/tb_mac_nibble_serial.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mac_nibble_serial.sv
// Nibble-serial multiply-accumulate: receives A then B LSB-nibble-first, adds A*B into a
// wide accumulator with one radix-16 partial product per cycle, then streams the result out.
module mac_nibble_serial #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned GUARD_BITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       signed_mode_i,
  input  logic       accumulate_i,
  input  logic [3:0] data_in_i,
  output logic [3:0] data_out_o,
  output logic       data_out_valid_o,
  output logic       result_last_o,
  output logic       ready_o
);

  localparam int unsigned N        = BIT_WIDTH / 4;
  localparam int unsigned AccWidth = 2 * BIT_WIDTH + GUARD_BITS;
  localparam int unsigned M        = AccWidth / 4;
  localparam int unsigned CntW     = $clog2(M);

  typedef enum logic [1:0] {
    StIdle,
    StRecvA,
    StRecvB,
    StSend
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]  a_q, a_d;
  logic [AccWidth-1:0]   acc_q, acc_d;
  logic                  signed_q, signed_d;

  logic [BIT_WIDTH-1:0]  a_shift;
  logic [AccWidth-1:0]   a_ext;
  logic [AccWidth-1:0]   nib_ext;
  logic [AccWidth-1:0]   prod_u;
  logic [AccWidth-1:0]   pp;
  logic                  nib_neg;
  logic                  cnt_last_n;
  logic                  cnt_last_m;
  logic [3:0]            out_nib;

  assign a_shift    = {data_in_i, a_q[BIT_WIDTH-1:4]};
  assign a_ext      = {{(AccWidth - BIT_WIDTH){signed_q & a_q[BIT_WIDTH-1]}}, a_q};
  assign nib_ext    = {{(AccWidth - 4){1'b0}}, data_in_i};
  assign cnt_last_n = (cnt_q == CntW'(N - 1));
  assign cnt_last_m = (cnt_q == CntW'(M - 1));

  // The top B nibble in signed mode weighs -8..7: unsigned value minus 16 when bit 3 is set.
  assign nib_neg = signed_q & cnt_last_n & data_in_i[3];
  assign prod_u  = a_ext * nib_ext;
  assign pp      = prod_u - (nib_neg ? {a_ext[AccWidth-5:0], 4'b0000} : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    acc_d    = acc_q;
    signed_d = signed_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d      = a_shift;
          signed_d = signed_mode_i;
          if (!accumulate_i) begin
            acc_d = '0;
          end
          cnt_d   = CntW'(1);
          state_d = StRecvA;
        end
      end
      StRecvA: begin
        a_d = a_shift;
        if (cnt_last_n) begin
          cnt_d   = '0;
          state_d = StRecvB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecvB: begin
        acc_d = acc_q + (pp << {cnt_q, 2'b00});
        if (cnt_last_n) begin
          cnt_d   = '0;
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSend: begin
        if (cnt_last_m) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      signed_q <= signed_d;
    end
  end

  always_comb begin
    out_nib = '0;
    for (int j = 0; j < int'(M); j++) begin
      if (cnt_q == CntW'(j)) begin
        out_nib = acc_q[4*j +: 4];
      end
    end
  end

  always_comb begin
    data_out_o       = '0;
    data_out_valid_o = 1'b0;
    result_last_o    = 1'b0;
    ready_o          = (state_q == StIdle);
    if (state_q == StSend) begin
      data_out_o       = out_nib;
      data_out_valid_o = 1'b1;
      result_last_o    = cnt_last_m;
    end
  end

endmodule

// File: tb/tb_mac_nibble_serial.sv
// Directed, table-driven bench for mac_nibble_serial at BIT_WIDTH=8, GUARD_BITS=8.
module tb_mac_nibble_serial;

  localparam int unsigned BW = 8;
  localparam int unsigned GB = 8;
  localparam int unsigned N  = BW / 4;
  localparam int unsigned AW = 2 * BW + GB;
  localparam int unsigned M  = AW / 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic       accumulate;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       data_out_valid;
  logic       result_last;
  logic       ready;

  int checks;
  int errors;

  typedef struct {
    logic          sm;
    logic          acc;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [AW-1:0] exp;
    logic          busy;
  } vec_t;

  vec_t vecs[9];

  mac_nibble_serial #(
    .BIT_WIDTH (BW),
    .GUARD_BITS(GB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .signed_mode_i   (signed_mode),
    .accumulate_i    (accumulate),
    .data_in_i       (data_in),
    .data_out_o      (data_out),
    .data_out_valid_o(data_out_valid),
    .result_last_o   (result_last),
    .ready_o         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, 32'(ready), 32'd1);
    check({name, "_valid"}, 32'(data_out_valid), 32'd0);
    check({name, "_dout"}, 32'(data_out), 32'd0);
    check({name, "_last"}, 32'(result_last), 32'd0);
  endtask

  // Full transaction starting at the current (idle) cycle; ends on cycle 2N+M, inputs idle.
  task automatic run_op(input logic sm, input logic acc, input logic [7:0] a,
                        input logic [7:0] b, input logic [AW-1:0] exp, input logic busy);
    logic [AW-1:0] e;
    e = exp;
    check("start_ready", 32'(ready), 32'd1);
    start       = 1'b1;
    signed_mode = sm;
    accumulate  = acc;
    data_in     = a[3:0];
    step();
    start       = 1'b0;
    signed_mode = ~sm;
    accumulate  = ~acc;
    for (int k = 1; k < int'(N); k++) begin
      data_in = a[4*k +: 4];
      check("recv_a_ready", 32'(ready), 32'd0);
      check("recv_a_valid", 32'(data_out_valid), 32'd0);
      step();
    end
    for (int k = 0; k < int'(N); k++) begin
      data_in = b[4*k +: 4];
      start   = busy;
      check("recv_b_valid", 32'(data_out_valid), 32'd0);
      check("recv_b_dout", 32'(data_out), 32'd0);
      step();
    end
    for (int j = 0; j < int'(M); j++) begin
      data_in = 4'($urandom);
      start   = busy;
      check("send_valid", 32'(data_out_valid), 32'd1);
      check("send_dout", 32'(data_out), 32'(e[4*j +: 4]));
      check("send_last", 32'(result_last), (j == int'(M) - 1) ? 32'd1 : 32'd0);
      check("send_ready", 32'(ready), 32'd0);
      step();
    end
    start = 1'b0;
    check_idle_outputs("done");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    accumulate  = 1'b0;
    data_in     = 4'h0;

    //         sm    acc   a      b      expected     busy
    vecs[0] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 24'h00FE01, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 8'h10, 24'h00FF01, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'h03, 8'h05, 24'h00000F, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h02, 24'hFFFFFE, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h80, 24'h004000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h01, 24'hFFFFFF, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h01, 8'h01, 24'h000000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h7F, 8'h80, 24'hFFC080, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 8'h02, 8'hFF, 24'hFFC07E, 1'b0};

    #3;
    check_idle_outputs("in_reset");
    step();
    step();
    rst = 1'b0;
    data_in = 4'hA;
    step();
    check_idle_outputs("post_reset");

    // Consecutive vectors start on the first ready cycle of the previous one.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].sm, vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].busy);
    end

    // Idle cycles with toggling data_in must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      data_in = 4'(i + 5);
      step();
      check_idle_outputs("idle_hold");
    end

    // Abort: accumulate=1 op reset during its second B nibble; accumulator must restart at 0.
    start      = 1'b1;
    accumulate = 1'b1;
    data_in    = 4'h5;
    step();
    start   = 1'b0;
    data_in = 4'h5;
    step();
    data_in = 4'h7;
    step();
    data_in = 4'h7;
    rst     = 1'b1;
    #1;
    check_idle_outputs("abort_now");
    step();
    check_idle_outputs("abort_held");
    rst = 1'b0;
    for (int i = 0; i < int'(M); i++) begin
      step();
      check("abort_no_valid", 32'(data_out_valid), 32'd0);
    end
    run_op(1'b0, 1'b1, 8'h02, 8'h03, 24'h000006, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
